cfg_issuer: RTL and testbench



---
 rtl/cfg_issuer.sv | 179 +++++++++++++++++
 tb/tb_cfg_issuer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_issuer.sv
// cfg_issuer: buffers host config descriptors and issues each one to the PE array as a one-cycle cfg_valid strobe.
// Latency: a descriptor accepted in cycle N is issued in cycle N+2 when cfg_busy is low in N+1; issues are at least 2 cycles after busy falls.
// Backpressure: desc_ready drops only when the descriptor FIFO is full; a pop frees a slot visible on the following cycle.

// Small generic synchronous FIFO; rd_dat shows the head entry combinationally.
module cfg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign wr_rdy = (count != (AW+1)'(DEPTH));
  assign rd_vld = (count != '0);
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; occupancy alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module cfg_issuer #(
  parameter int DATA_CWIDTH = 8,
  parameter int WICP_CWIDTH = 16,
  parameter int TMPC_CWIDTH = 8,
  parameter int POST_CWIDTH = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [DATA_CWIDTH-1:0] desc_data_data,
  input  logic [WICP_CWIDTH-1:0] desc_wicp_data,
  input  logic [TMPC_CWIDTH-1:0] desc_tmpc_data,
  input  logic [POST_CWIDTH-1:0] desc_post_data,
  output logic                   cfg_valid,
  output logic [DATA_CWIDTH-1:0] cfg_data_data,
  output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
  output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
  output logic [POST_CWIDTH-1:0] cfg_post_data,
  input  logic                   cfg_busy,
  output logic                   idle,
  output logic                   err_timeout,
  output logic [7:0]             issued_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [DATA_CWIDTH-1:0] data;
    logic [WICP_CWIDTH-1:0] wicp;
    logic [TMPC_CWIDTH-1:0] tmpc;
    logic [POST_CWIDTH-1:0] post;
  } desc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RISE,
    S_WAIT_FALL
  } state_t;

  state_t        state;
  desc_t         push_desc;
  desc_t         head_desc;
  logic          fifo_vld;
  logic          pop;
  logic [TW-1:0] tmo_cnt;

  assign push_desc.data = desc_data_data;
  assign push_desc.wicp = desc_wicp_data;
  assign push_desc.tmpc = desc_tmpc_data;
  assign push_desc.post = desc_post_data;

  // A residual busy from the previous target blocks the pop, so IDLE simply waits it out.
  assign pop  = (state == S_IDLE) && fifo_vld && !cfg_busy;
  assign idle = (state == S_IDLE) && !fifo_vld;

  cfg_fifo #(
    .WIDTH ($bits(desc_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (desc_valid),
    .wr_rdy (desc_ready),
    .wr_dat (push_desc),
    .rd_vld (fifo_vld),
    .rd_rdy (pop),
    .rd_dat (head_desc)
  );

  // Issue FSM: pop into output registers, strobe once, then track the target's busy window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cfg_valid     <= 1'b0;
      cfg_data_data <= '0;
      cfg_wicp_data <= '0;
      cfg_tmpc_data <= '0;
      cfg_post_data <= '0;
      issued_cnt    <= '0;
      err_timeout   <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      cfg_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cfg_data_data <= head_desc.data;
            cfg_wicp_data <= head_desc.wicp;
            cfg_tmpc_data <= head_desc.tmpc;
            cfg_post_data <= head_desc.post;
            cfg_valid     <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // cfg_busy is deliberately ignored here; the target may not have reacted yet.
          issued_cnt <= issued_cnt + 8'd1;
          tmo_cnt    <= '0;
          state      <= S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          if (cfg_busy) begin
            state <= S_WAIT_FALL;
          end else if (tmo_cnt == TMO_LAST) begin
            // Target never acknowledged; flag it and move on so the queue does not stall.
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (!cfg_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_issuer.sv
module tb_cfg_issuer;
  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [7:0]  desc_data_data;
  logic [15:0] desc_wicp_data;
  logic [7:0]  desc_tmpc_data;
  logic [7:0]  desc_post_data;
  logic        cfg_valid;
  logic [7:0]  cfg_data_data;
  logic [15:0] cfg_wicp_data;
  logic [7:0]  cfg_tmpc_data;
  logic [7:0]  cfg_post_data;
  logic        cfg_busy;
  logic        idle;
  logic        err_timeout;
  logic [7:0]  issued_cnt;

  always #5 clk = ~clk;

  cfg_issuer #(
    .DATA_CWIDTH (8),
    .WICP_CWIDTH (16),
    .TMPC_CWIDTH (8),
    .POST_CWIDTH (8),
    .DEPTH       (4),
    .TIMEOUT     (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_data_data (desc_data_data),
    .desc_wicp_data (desc_wicp_data),
    .desc_tmpc_data (desc_tmpc_data),
    .desc_post_data (desc_post_data),
    .cfg_valid      (cfg_valid),
    .cfg_data_data  (cfg_data_data),
    .cfg_wicp_data  (cfg_wicp_data),
    .cfg_tmpc_data  (cfg_tmpc_data),
    .cfg_post_data  (cfg_post_data),
    .cfg_busy       (cfg_busy),
    .idle           (idle),
    .err_timeout    (err_timeout),
    .issued_cnt     (issued_cnt)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] w;
    logic [7:0]  t;
    logic [7:0]  p;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   last_valid_cyc = -1;

  // Target model: after each strobe, raise busy resp_dly cycles later for resp_len cycles.
  logic resp_en = 1'b0;
  logic resp_busy = 1'b0;
  logic busy_force = 1'b0;
  int   resp_dly = 2;
  int   resp_len = 5;
  int   rise_at = 0;
  int   fall_at = 0;

  assign cfg_busy = resp_busy | busy_force;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending descriptor.
  initial begin : monitor
    exp_t e;
    logic prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        chk("no_back_to_back", {31'd0, prev_vld}, 32'd0);
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue: cfg_valid with no pending descriptor at cycle %0d", cyc);
        end else begin
          e = expq.pop_front();
          chk("sb_data", {24'd0, cfg_data_data}, {24'd0, e.d});
          chk("sb_wicp", {16'd0, cfg_wicp_data}, {16'd0, e.w});
          chk("sb_tmpc", {24'd0, cfg_tmpc_data}, {24'd0, e.t});
          chk("sb_post", {24'd0, cfg_post_data}, {24'd0, e.p});
        end
      end
      prev_vld = cfg_valid;
    end
  end

  // Target responder.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (cfg_valid === 1'b1 && resp_en) begin
        rise_at = cyc + resp_dly;
        fall_at = rise_at + resp_len;
      end
      resp_busy = (cyc >= rise_at) && (cyc < fall_at);
    end
  end

  task automatic push(input logic [7:0] d, input logic [15:0] w, input logic [7:0] t,
                      input logic [7:0] p, output logic acc, output int acc_cyc);
    exp_t e;
    desc_valid     = 1'b1;
    desc_data_data = d;
    desc_wicp_data = w;
    desc_tmpc_data = t;
    desc_post_data = p;
    acc     = desc_ready;
    acc_cyc = cyc;
    if (acc) begin
      e.d = d; e.w = w; e.t = t; e.p = p;
      expq.push_back(e);
    end
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic push_retry(input logic [7:0] d, input logic [15:0] w, input logic [7:0] t,
                            input logic [7:0] p);
    logic acc;
    int   ac;
    int   n;
    n = 0;
    while (desc_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (desc_ready !== 1'b1) fail_now("push_retry_ready");
    else push(d, w, t, p, acc, ac);
  endtask

  task automatic wait_valid(input int target, input int max, input string name);
    int n;
    n = 0;
    while (valid_cnt < target && n < max) begin
      tick();
      n++;
    end
    if (valid_cnt < target) fail_now(name);
  endtask

  task automatic wait_quiet(input int max, input string name);
    int n;
    n = 0;
    while (!(idle === 1'b1 && cfg_busy === 1'b0) && n < max) begin
      tick();
      n++;
    end
    if (!(idle === 1'b1 && cfg_busy === 1'b0)) fail_now(name);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic       acc;
    int         ac;
    int         ac0;
    int         base;
    logic [7:0] b;

    rst = 1'b1;
    desc_valid = 1'b0;
    desc_data_data = '0;
    desc_wicp_data = '0;
    desc_tmpc_data = '0;
    desc_post_data = '0;
    repeat (3) tick();

    chk("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_cfg_data", {24'd0, cfg_data_data}, 32'd0);
    chk("rst_cfg_wicp", {16'd0, cfg_wicp_data}, 32'd0);
    chk("rst_cfg_tmpc", {24'd0, cfg_tmpc_data}, 32'd0);
    chk("rst_cfg_post", {24'd0, cfg_post_data}, 32'd0);
    chk("rst_issued_cnt", {24'd0, issued_cnt}, 32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("rst_desc_ready", {31'd0, desc_ready}, 32'd1);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b0;
    repeat (5) tick();

    // Single descriptor: issue at N+2, busy 2 cycles after for 5 cycles.
    resp_en = 1'b1; resp_dly = 2; resp_len = 5;
    push(8'h5A, 16'h1234, 8'h03, 8'h7F, acc, ac);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    tick();
    chk("t1_valid_n2", {31'd0, cfg_valid}, 32'd1);
    tick();
    chk("t1_valid_pulse", {31'd0, cfg_valid}, 32'd0);
    repeat (6) tick();
    chk("t1_not_idle_in_busy", {31'd0, idle}, 32'd0);
    tick();
    chk("t1_idle_after_busy", {31'd0, idle}, 32'd1);
    chk("t1_issued_cnt", {24'd0, issued_cnt}, 32'd1);
    chk("t1_fields_held", {24'd0, cfg_data_data}, 32'h5A);
    chk("t1_issue_cycle", last_valid_cyc, ac + 2);
    chk("t1_valid_count", valid_cnt, 1);

    // Fill and drain: busy held high, only DEPTH descriptors fit.
    busy_force = 1'b1; resp_dly = 1; resp_len = 3;
    base = valid_cnt;
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), 16'hA000 + 16'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), acc, ac);
      chk("t2_accept", {31'd0, acc}, (i < 4) ? 32'd1 : 32'd0);
    end
    chk("t2_full_ready", {31'd0, desc_ready}, 32'd0);
    chk("t2_held_off", valid_cnt, base);
    busy_force = 1'b0;
    tick();
    chk("t2_issue_after_release", {31'd0, cfg_valid}, 32'd1);
    chk("t2_ready_after_pop", {31'd0, desc_ready}, 32'd1);
    wait_valid(base + 4, 200, "t2_wait_issues");
    wait_quiet(50, "t2_wait_quiet");
    chk("t2_issued_cnt", {24'd0, issued_cnt}, 32'd5);
    chk("t2_queue_drained", expq.size(), 0);

    // Timeout: target never answers.
    resp_en = 1'b0;
    push(8'hC3, 16'hBEEF, 8'h44, 8'h55, acc, ac);
    tick();
    chk("t3_issue", {31'd0, cfg_valid}, 32'd1);
    repeat (15) tick();
    chk("t3_err_not_yet", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("t3_err_set", {31'd0, err_timeout}, 32'd1);
    chk("t3_idle_at_err", {31'd0, idle}, 32'd1);
    resp_en = 1'b1; resp_dly = 1; resp_len = 2;
    base = valid_cnt;
    push(8'h9E, 16'h0F0F, 8'h12, 8'h34, acc, ac);
    wait_valid(base + 1, 20, "t3_second_issue");
    wait_quiet(50, "t3_wait_quiet");
    chk("t3_err_sticky", {31'd0, err_timeout}, 32'd1);
    chk("t3_issued_cnt", {24'd0, issued_cnt}, 32'd7);

    // Residual busy blocks issue until it drops.
    busy_force = 1'b1;
    base = valid_cnt;
    push(8'h66, 16'h7777, 8'h88, 8'h99, acc, ac);
    repeat (4) tick();
    chk("t4_no_issue_while_busy", valid_cnt, base);
    busy_force = 1'b0;
    tick();
    chk("t4_issue_one_later", {31'd0, cfg_valid}, 32'd1);
    wait_quiet(50, "t4_wait_quiet");
    chk("t4_issued_cnt", {24'd0, issued_cnt}, 32'd8);

    // Reset during WAIT_FALL with two descriptors still queued.
    resp_dly = 1; resp_len = 20;
    push(8'hA1, 16'h1111, 8'hB1, 8'hC1, acc, ac0);
    push(8'hA2, 16'h2222, 8'hB2, 8'hC2, acc, ac);
    push(8'hA3, 16'h3333, 8'hB3, 8'hC3, acc, ac);
    repeat (3) tick();
    chk("t5_busy_phase_not_idle", {31'd0, idle}, 32'd0);
    chk("t5_one_issued", last_valid_cyc, ac0 + 2);
    rst = 1'b1;
    expq.delete();
    tick();
    rst = 1'b0;
    chk("t5_valid_low", {31'd0, cfg_valid}, 32'd0);
    chk("t5_idle", {31'd0, idle}, 32'd1);
    chk("t5_cnt_cleared", {24'd0, issued_cnt}, 32'd0);
    chk("t5_err_cleared", {31'd0, err_timeout}, 32'd0);
    chk("t5_ready", {31'd0, desc_ready}, 32'd1);
    chk("t5_fields_cleared", {24'd0, cfg_data_data}, 32'd0);
    base = valid_cnt;
    repeat (40) tick();
    chk("t5_no_further_issue", valid_cnt, base);
    chk("t5_still_idle", {31'd0, idle}, 32'd1);

    // Counter wrap: 256 issues with a 1-cycle busy each.
    resp_dly = 1; resp_len = 1;
    base = valid_cnt;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (i == 255) chk("t6_cnt_before_last", {24'd0, issued_cnt} <= 32'd254, 32'd1);
      push_retry(b, {8'hE0, b}, ~b, b ^ 8'h5A);
    end
    wait_valid(base + 256, 3000, "t6_wait_issues");
    wait_quiet(50, "t6_wait_quiet");
    chk("t6_issue_count", valid_cnt - base, 256);
    chk("t6_cnt_wrapped", {24'd0, issued_cnt}, 32'd0);
    chk("t6_queue_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
